// File: rtl/code_lock_pkg.sv
// ---------------------------------------------------------------------------
// code_lock_pkg
// Shared definitions for the serial code-lock controller: the controller
// state encoding and small helpers for sizing counters.
// ---------------------------------------------------------------------------
package code_lock_pkg;

  typedef enum logic [1:0] {
    ENTRY   = 2'b00,
    OPEN    = 2'b01,
    FAIL    = 2'b10,
    LOCKOUT = 2'b11
  } lock_state_t;

  // Bits needed to hold any value 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // The one shared timer must cover the longer of the two timed windows.
  function automatic int timer_width(input int open_cycles, input int lockout_cycles);
    return cnt_width((open_cycles > lockout_cycles) ? open_cycles : lockout_cycles);
  endfunction

endpackage

// File: rtl/code_lock_fsm_timer.sv
// ---------------------------------------------------------------------------
// lock_timer
// Load/decrement down-counter shared by the OPEN window and the lockout.
// The controller loads N-1 on entering a timed state, so the state lasts
// exactly N cycles ending on the cycle the count is zero.
// Ports:
//   Clk, Rst   clock, synchronous active-high reset (count -> 0)
//   load       load load_val this edge (has priority over counting)
//   en         count down while nonzero
//   load_val   value to load
//   done       count is zero
// ---------------------------------------------------------------------------
module lock_timer #(
  parameter int W = 4
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  // Down-counter that parks at zero until it is reloaded.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/code_lock_fsm.sv
// ---------------------------------------------------------------------------
// code_lock_fsm
// Serial code-lock controller. One key bit arrives per Key_valid strobe and
// is compared against the stored code, MSB first. A full correct entry opens
// the lock for OPEN_CYCLES; a wrong entry costs a try, and running out of
// tries triggers a LOCKOUT_CYCLES lockout.
//
// Optional feature macro: CODE_LOCK_PROG_EN
//   defined   -> Prog_load / New_code ports; code reprogrammable while open
//   undefined -> code is the constant CODE
//
// Ports:
//   Clk, Rst     clock, synchronous active-high reset
//   Key_valid    key press present this cycle
//   B            key value, sampled when Key_valid=1
//   Relock       abort partial entry / close the lock early
//   Prog_load    (CODE_LOCK_PROG_EN) load New_code while open
//   New_code     (CODE_LOCK_PROG_EN) replacement code
//   Out          lock open
//   Err          wrong entry or lockout
//   Locked_out   lockout active
//   Tries_left   remaining attempts
// ---------------------------------------------------------------------------
module code_lock_fsm
  import code_lock_pkg::*;
#(
  parameter int                CODE_LEN       = 4,
  parameter logic [CODE_LEN-1:0] CODE         = 4'b1010,
  parameter int                MAX_TRIES      = 3,
  parameter int                OPEN_CYCLES    = 8,
  parameter int                LOCKOUT_CYCLES = 16
) (
  input  logic                               Clk,
  input  logic                               Rst,
  input  logic                               Key_valid,
  input  logic                               B,
  input  logic                               Relock,
`ifdef CODE_LOCK_PROG_EN
  input  logic                               Prog_load,
  input  logic [CODE_LEN-1:0]                New_code,
`endif
  output logic                               Out,
  output logic                               Err,
  output logic                               Locked_out,
  output logic [$clog2(MAX_TRIES+1)-1:0]     Tries_left
);

  localparam int KW  = cnt_width(CODE_LEN);
  localparam int TW  = $clog2(MAX_TRIES + 1);
  localparam int TMW = timer_width(OPEN_CYCLES, LOCKOUT_CYCLES);

  lock_state_t       state;
  logic [KW-1:0]     key_cnt;
  logic              miss;
  logic [CODE_LEN-1:0] code_w;
  logic              exp_bit;
  logic              key_take;
  logic              last_key;
  logic              entry_ok;
  logic              entry_bad;
  logic              lock_enter;
  logic              tmr_load;
  logic [TMW-1:0]    tmr_val;
  logic              tmr_en;
  logic              tmr_done;

`ifdef CODE_LOCK_PROG_EN
  logic [CODE_LEN-1:0] code_q;

  // Programmable code: only reloadable while the lock is open, so a
  // stranger cannot change it without first knowing the current code.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      code_q <= CODE;
    end else if ((state == OPEN) && Prog_load) begin
      code_q <= New_code;
    end
  end

  assign code_w = code_q;
`else
  assign code_w = CODE;
`endif

  // Select the code bit for the current key position; the first key
  // is compared with the MSB.
  always_comb begin
    exp_bit = 1'b0;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (int'(key_cnt) == (CODE_LEN - 1 - i)) begin
        exp_bit = code_w[i];
      end
    end
  end

  // Relock beats a simultaneous key, so the key is only taken without it.
  assign key_take   = (state == ENTRY) && Key_valid && !Relock;
  assign last_key   = (key_cnt == KW'(CODE_LEN - 1));
  assign entry_ok   = key_take && last_key && !miss && (B == exp_bit);
  assign entry_bad  = key_take && last_key && (miss || (B != exp_bit));
  assign lock_enter = (state == FAIL) && (Tries_left == '0);

  // The timer is loaded on the same edge that enters OPEN or LOCKOUT.
  assign tmr_load = entry_ok || lock_enter;
  assign tmr_val  = entry_ok ? TMW'(OPEN_CYCLES - 1) : TMW'(LOCKOUT_CYCLES - 1);
  assign tmr_en   = (state == OPEN) || (state == LOCKOUT);

  lock_timer #(.W(TMW)) u_timer (
    .Clk      (Clk),
    .Rst      (Rst),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Controller state, entry tracking and registered Moore outputs. The
  // outputs are written alongside every state change so they always
  // reflect the state held in the register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= ENTRY;
      key_cnt    <= '0;
      miss       <= 1'b0;
      Out        <= 1'b0;
      Err        <= 1'b0;
      Locked_out <= 1'b0;
      Tries_left <= TW'(MAX_TRIES);
    end else begin
      case (state)
        ENTRY: begin
          if (Relock) begin
            key_cnt <= '0;
            miss    <= 1'b0;
          end else if (Key_valid) begin
            if (last_key) begin
              key_cnt <= '0;
              miss    <= 1'b0;
              if (entry_ok) begin
                state      <= OPEN;
                Out        <= 1'b1;
                Tries_left <= TW'(MAX_TRIES);
              end else begin
                state <= FAIL;
                Err   <= 1'b1;
                if (Tries_left != '0) begin
                  Tries_left <= Tries_left - TW'(1);
                end
              end
            end else begin
              // Mismatches are remembered but not reported until the
              // entry is complete, so the wrong position is not leaked.
              key_cnt <= key_cnt + KW'(1);
              miss    <= miss | (B != exp_bit);
            end
          end
        end

        OPEN: begin
          if (Relock || tmr_done) begin
            state <= ENTRY;
            Out   <= 1'b0;
          end
        end

        FAIL: begin
          if (lock_enter) begin
            state      <= LOCKOUT;
            Locked_out <= 1'b1;
          end else begin
            state <= ENTRY;
            Err   <= 1'b0;
          end
        end

        LOCKOUT: begin
          if (tmr_done) begin
            state      <= ENTRY;
            Err        <= 1'b0;
            Locked_out <= 1'b0;
            Tries_left <= TW'(MAX_TRIES);
          end
        end

        default: begin
          state <= ENTRY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_code_lock_fsm.sv
// ---------------------------------------------------------------------------
// tb_code_lock_fsm
// Self-checking bench for code_lock_fsm with default parameters. A
// behavioural model based on remaining-cycle counts and a key queue runs
// beside the DUT and every output is compared on each negative edge;
// directed scenarios also pin specific literal values.
// ---------------------------------------------------------------------------
module tb_code_lock_fsm;

  localparam int            CODE_LEN       = 4;
  localparam logic [3:0]    CODE           = 4'b1010;
  localparam int            MAX_TRIES      = 3;
  localparam int            OPEN_CYCLES    = 8;
  localparam int            LOCKOUT_CYCLES = 16;
  localparam int            TW             = $clog2(MAX_TRIES + 1);

  logic          Clk;
  logic          Rst;
  logic          Key_valid;
  logic          B;
  logic          Relock;
  logic          Prog_load;
  logic [3:0]    New_code;
  logic          Out;
  logic          Err;
  logic          Locked_out;
  logic [TW-1:0] Tries_left;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  // Behavioural model state
  int         m_open_left;
  int         m_lock_left;
  bit         m_fail;
  int         m_tries;
  bit         m_q[$];
  logic [3:0] m_code;
  int         m_v;

  code_lock_fsm #(
    .CODE_LEN       (CODE_LEN),
    .CODE           (CODE),
    .MAX_TRIES      (MAX_TRIES),
    .OPEN_CYCLES    (OPEN_CYCLES),
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Key_valid  (Key_valid),
    .B          (B),
    .Relock     (Relock),
`ifdef CODE_LOCK_PROG_EN
    .Prog_load  (Prog_load),
    .New_code   (New_code),
`endif
    .Out        (Out),
    .Err        (Err),
    .Locked_out (Locked_out),
    .Tries_left (Tries_left)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: the lock is described by how many open or lockout
  // cycles remain, a pending one-cycle failure, and the keys typed so far.
  always @(posedge Clk) begin
    if (Rst) begin
      m_open_left = 0;
      m_lock_left = 0;
      m_fail      = 0;
      m_tries     = MAX_TRIES;
      m_q.delete();
      m_code      = CODE;
    end else if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_tries = MAX_TRIES;
    end else if (m_fail) begin
      m_fail = 0;
      if (m_tries == 0) m_lock_left = LOCKOUT_CYCLES;
    end else if (m_open_left > 0) begin
`ifdef CODE_LOCK_PROG_EN
      if (Prog_load) m_code = New_code;
`endif
      m_open_left = Relock ? 0 : m_open_left - 1;
    end else if (Relock) begin
      m_q.delete();
    end else if (Key_valid) begin
      m_q.push_back(B);
      if (m_q.size() == CODE_LEN) begin
        m_v = 0;
        foreach (m_q[i]) m_v = m_v * 2 + int'(m_q[i]);
        m_q.delete();
        if (m_v == int'(m_code)) begin
          m_open_left = OPEN_CYCLES;
          m_tries     = MAX_TRIES;
        end else begin
          m_fail  = 1;
          m_tries = m_tries - 1;
        end
      end
    end
  end

  // One comparison with counting and failure reporting.
  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Every cycle, the DUT outputs must match the model.
  always @(negedge Clk) begin
    if (chk_en) begin
      checkOutput("model_out",    32'(Out),        32'(m_open_left > 0));
      checkOutput("model_err",    32'(Err),        32'(m_fail || (m_lock_left > 0)));
      checkOutput("model_locked", 32'(Locked_out), 32'(m_lock_left > 0));
      checkOutput("model_tries",  32'(Tries_left), 32'(m_tries));
    end
  end

  // Drive one cycle of inputs, then return 1 time unit after the edge.
  task automatic applyStimulus(input bit kv, input bit b, input bit rl, input bit rs);
    Key_valid = kv;
    B         = b;
    Relock    = rl;
    Rst       = rs;
    @(posedge Clk);
    #1;
    Key_valid = 1'b0;
    Relock    = 1'b0;
    Rst       = 1'b0;
  endtask

  task automatic enterCode(input logic [3:0] c);
    for (int i = 3; i >= 0; i--) applyStimulus(1'b1, c[i], 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Three wrong entries, each followed by its FAIL cycle except the last.
  task automatic threeWrong();
    enterCode(4'b0000);
    idle(1);
    enterCode(4'b0001);
    idle(1);
    enterCode(4'b1111);
  endtask

  initial begin
    int n;
    bit rl;
    logic [3:0] c;
    Rst = 1'b1; Key_valid = 1'b0; B = 1'b0; Relock = 1'b0;
    Prog_load = 1'b0; New_code = 4'b0000;

    // Reset state
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    chk_en = 1;
    checkOutput("reset_out",    32'(Out),        32'd0);
    checkOutput("reset_err",    32'(Err),        32'd0);
    checkOutput("reset_locked", 32'(Locked_out), 32'd0);
    checkOutput("reset_tries",  32'(Tries_left), 32'd3);

    // Correct entry opens for exactly 8 cycles
    enterCode(4'b1010);
    checkOutput("open_latency", 32'(Out), 32'd1);
    checkOutput("open_tries",   32'(Tries_left), 32'd3);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (Out) n++;
      idle(1);
    end
    checkOutput("open_len", 32'(n), 32'd8);

    // Wrong entry: no early error, one-cycle Err pulse, try consumed
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("no_early_err", 32'(Err), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("fail_err",   32'(Err),        32'd1);
    checkOutput("fail_tries", 32'(Tries_left), 32'd2);
    idle(1);
    checkOutput("fail_pulse", 32'(Err), 32'd0);

    // Lockout after three wrong entries; keys ignored during it
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    threeWrong();
    checkOutput("third_fail_err",    32'(Err),        32'd1);
    checkOutput("third_fail_locked", 32'(Locked_out), 32'd0);
    checkOutput("third_fail_tries",  32'(Tries_left), 32'd0);
    idle(1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!Locked_out) break;
      n++;
      applyStimulus(1'b1, CODE[3 - (i % 4)], 1'b0, 1'b0);
    end
    checkOutput("lockout_len",   32'(n),          32'd16);
    checkOutput("lockout_tries", 32'(Tries_left), 32'd3);
    enterCode(4'b1010);
    checkOutput("post_lock_open", 32'(Out), 32'd1);

    // Relock on the third open cycle closes on the next edge
    idle(2);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("relock_close", 32'(Out), 32'd0);

    // Relock with a key discards the partial entry without using a try
    enterCode(4'b0110);
    idle(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("abort_tries", 32'(Tries_left), 32'd2);
    enterCode(4'b1010);
    checkOutput("abort_open", 32'(Out), 32'd1);
    idle(OPEN_CYCLES);

    // Reset mid-lockout
    threeWrong();
    idle(5);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("rst_lock_out",    32'(Out),        32'd0);
    checkOutput("rst_lock_err",    32'(Err),        32'd0);
    checkOutput("rst_lock_locked", 32'(Locked_out), 32'd0);
    checkOutput("rst_lock_tries",  32'(Tries_left), 32'd3);

`ifdef CODE_LOCK_PROG_EN
    // Reprogram while open, then verify old/new codes and reset revert
    enterCode(4'b1010);
    Prog_load = 1'b1;
    New_code  = 4'b0110;
    idle(1);
    Prog_load = 1'b0;
    idle(OPEN_CYCLES);
    enterCode(4'b1010);
    checkOutput("prog_old_err", 32'(Err), 32'd1);
    idle(1);
    enterCode(4'b0110);
    checkOutput("prog_new_open", 32'(Out), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    enterCode(4'b1010);
    checkOutput("prog_rst_open", 32'(Out), 32'd1);
    idle(OPEN_CYCLES);
`endif

    // Randomized entries checked against the model every cycle
    for (int e = 0; e < 80; e++) begin
      int mode;
      mode = int'($urandom_range(0, 19));
      if (mode == 0) begin
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      end else begin
        c = (mode < 9) ? CODE : 4'($urandom_range(0, 15));
        for (int i = 3; i >= 0; i--) begin
          if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
          rl = ($urandom_range(0, 15) == 0);
`ifdef CODE_LOCK_PROG_EN
          Prog_load = ($urandom_range(0, 7) == 0);
          New_code  = ($urandom_range(0, 1) == 0) ? CODE : 4'($urandom_range(0, 15));
`endif
          applyStimulus(1'b1, c[i], rl, 1'b0);
`ifdef CODE_LOCK_PROG_EN
          Prog_load = 1'b0;
`endif
        end
        idle(int'($urandom_range(0, 4)));
      end
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
